// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: packs field-level descriptors into 32-bit MIPS words, buffers them in a FIFO
// and writes them to instruction memory at word-aligned, auto-incrementing byte addresses.
module mips_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 9,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enc_valid,
  output logic              enc_ready,
  input  logic [1:0]        enc_format,
  input  logic [5:0]        enc_op,
  input  logic [5:0]        enc_funct,
  input  logic [4:0]        enc_rs,
  input  logic [4:0]        enc_rt,
  input  logic [4:0]        enc_rd,
  input  logic [4:0]        enc_shamt,
  input  logic [15:0]       enc_imm,
  input  logic [25:0]       enc_target,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic [15:0]       words_written
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]       r_fifo [DEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_words;
  logic [31:0]       w_word;
  logic              w_push;
  logic              w_pop;
  always_comb begin
    w_word = enc_format == 2'd0 ? {6'b000000, enc_rs, enc_rt, enc_rd, enc_shamt, enc_funct}
           : enc_format == 2'd1 ? {enc_op, enc_rs, enc_rt, enc_imm}
           : enc_format == 2'd2 ? {enc_op, enc_target}
           : {6'b000001, enc_rs, enc_rt, enc_imm};
  end
  assign enc_ready     = r_cnt < CW'(DEPTH);
  assign busy          = r_cnt != '0;
  assign mem_req       = busy;
  assign mem_addr      = r_addr;
  // Head is masked while empty so stale storage never shows on the bus
  assign mem_wdata     = busy ? r_fifo[r_rp] : 32'd0;
  assign words_written = r_words;
  assign w_push        = enc_valid && enc_ready;
  assign w_pop         = mem_req && mem_gnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_addr  <= ADDR_W'(BASE_ADDR);
      r_words <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop) begin
        r_rp    <= r_rp + PW'(1);
        r_addr  <= r_addr + ADDR_W'(4);
        r_words <= r_words + 16'd1;
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= w_word;
  end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: directed vectors for packing, backpressure, push/pop overlap, address wrap and reset.
module tb_mips_instr_encoder;
  logic        clk = 1'b0;
  logic        reset;
  logic        enc_valid;
  logic        enc_ready;
  logic [1:0]  enc_format;
  logic [5:0]  enc_op;
  logic [5:0]  enc_funct;
  logic [4:0]  enc_rs;
  logic [4:0]  enc_rt;
  logic [4:0]  enc_rd;
  logic [4:0]  enc_shamt;
  logic [15:0] enc_imm;
  logic [25:0] enc_target;
  logic        mem_req;
  logic        mem_gnt;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic [15:0] words_written;

  int checks = 0;
  int errors = 0;
  logic [8:0]  exp_addr;
  logic [15:0] exp_words;

  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  mips_instr_encoder #(.DEPTH(4), .ADDR_W(9), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .enc_valid(enc_valid), .enc_ready(enc_ready),
    .enc_format(enc_format), .enc_op(enc_op), .enc_funct(enc_funct), .enc_rs(enc_rs),
    .enc_rt(enc_rt), .enc_rd(enc_rd), .enc_shamt(enc_shamt), .enc_imm(enc_imm),
    .enc_target(enc_target), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .words_written(words_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    enc_format = v.fmt;
    enc_op     = v.op;
    enc_funct  = v.funct;
    enc_rs     = v.rs;
    enc_rt     = v.rt;
    enc_rd     = v.rd;
    enc_shamt  = v.shamt;
    enc_imm    = v.imm;
    enc_target = v.target;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enc_valid = 1'b0;
    mem_gnt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_addr = 9'd0;
    exp_words = 16'd0;
  endtask

  // One descriptor with the memory always granting: written the next cycle, drained the one after
  task automatic push_one(input vec_t v, input string name);
    drive(v);
    enc_valid = 1'b1;
    mem_gnt = 1'b1;
    @(negedge clk);
    enc_valid = 1'b0;
    chk({name, ".req"}, 32'(mem_req), 32'd1);
    chk({name, ".addr"}, 32'(mem_addr), 32'(exp_addr));
    chk({name, ".wdata"}, mem_wdata, v.exp);
    @(negedge clk);
    exp_addr = exp_addr + 9'd4;
    exp_words = exp_words + 16'd1;
    chk({name, ".busy"}, 32'(busy), 32'd0);
    chk({name, ".words"}, 32'(words_written), 32'(exp_words));
  endtask

  initial begin
    vecs[0] = '{2'd0, 6'h00, 6'b100001, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'h0, 32'h00221821};
    vecs[1] = '{2'd1, 6'b001001, 6'h00, 5'd0, 5'd5, 5'd0, 5'd0, 16'hFFFF, 26'h0, 32'h2405FFFF};
    vecs[2] = '{2'd2, 6'b000010, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h10, 32'h08000010};
    vecs[3] = '{2'd3, 6'h00, 6'h00, 5'd4, 5'd1, 5'd0, 5'd0, 16'h0003, 26'h0, 32'h04810003};
    vecs[4] = '{2'd0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0, 32'h00000000};
    vecs[5] = '{2'd1, 6'b100011, 6'h3F, 5'd29, 5'd8, 5'd31, 5'd31, 16'h0010, 26'h3FFFFFF, 32'h8FA80010};
    vecs[6] = '{2'd0, 6'h3F, 6'h00, 5'd0, 5'd3, 5'd2, 5'd4, 16'hBEEF, 26'h3FFFFFF, 32'h00031100};
    vecs[7] = '{2'd3, 6'h23, 6'h3F, 5'd5, 5'd0, 5'd31, 5'd31, 16'hFFFE, 26'h1234567, 32'h04A0FFFE};
    drive(vecs[4]);
    do_reset();
    chk("rst.ready", 32'(enc_ready), 32'd1);
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.addr", 32'(mem_addr), 32'd0);
    chk("rst.wdata", mem_wdata, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.words", 32'(words_written), 32'd0);

    for (int i = 0; i < 8; i++) push_one(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: fill the FIFO with the memory stalled
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(vecs[i]);
      enc_valid = 1'b1;
      @(negedge clk);
    end
    chk("bp.ready_full", 32'(enc_ready), 32'd0);
    chk("bp.addr", 32'(mem_addr), 32'd0);
    chk("bp.wdata", mem_wdata, vecs[0].exp);
    drive(vecs[5]);
    @(negedge clk);
    @(negedge clk);
    enc_valid = 1'b0;
    chk("bp.addr_hold", 32'(mem_addr), 32'd0);
    chk("bp.wdata_hold", mem_wdata, vecs[0].exp);
    chk("bp.req_hold", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp.drain%0d.addr", i), 32'(mem_addr), 32'(4 * i));
      chk($sformatf("bp.drain%0d.wdata", i), mem_wdata, vecs[i].exp);
      @(negedge clk);
      if (i == 0) chk("bp.ready_after_pop", 32'(enc_ready), 32'd1);
    end
    chk("bp.empty", 32'(busy), 32'd0);
    chk("bp.words", 32'(words_written), 32'd4);

    // Overlapping push and pop with two words buffered
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(vecs[i]);
      enc_valid = 1'b1;
      @(negedge clk);
    end
    mem_gnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(vecs[i + 2]);
      enc_valid = i < 3;
      chk($sformatf("ov%0d.req", i), 32'(mem_req), 32'd1);
      chk($sformatf("ov%0d.addr", i), 32'(mem_addr), 32'(4 * i));
      chk($sformatf("ov%0d.wdata", i), mem_wdata, vecs[i].exp);
      if (i < 3) chk($sformatf("ov%0d.ready", i), 32'(enc_ready), 32'd1);
      @(negedge clk);
    end
    chk("ov.empty", 32'(busy), 32'd0);
    chk("ov.words", 32'(words_written), 32'd5);

    // Address wrap at the top of the 9-bit byte space
    do_reset();
    drive(vecs[4]);
    mem_gnt = 1'b1;
    for (int i = 0; i < 127; i++) begin
      enc_valid = 1'b1;
      @(negedge clk);
      enc_valid = 1'b0;
      @(negedge clk);
    end
    chk("wrap.addr_pre", 32'(mem_addr), 32'd508);
    chk("wrap.words_pre", 32'(words_written), 32'd127);
    exp_addr = 9'd508;
    exp_words = 16'd127;
    push_one(vecs[1], "wrap.a");
    push_one(vecs[2], "wrap.b");

    // Reset with three words stuck behind a stalled memory
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(vecs[i + 5]);
      enc_valid = 1'b1;
      @(negedge clk);
    end
    enc_valid = 1'b0;
    chk("mid.busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid.req", 32'(mem_req), 32'd0);
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.addr", 32'(mem_addr), 32'd0);
    chk("mid.words", 32'(words_written), 32'd0);
    chk("mid.ready", 32'(enc_ready), 32'd1);
    exp_addr = 9'd0;
    exp_words = 16'd0;
    push_one(vecs[3], "mid.new");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
